fifo_burst_reader: RTL and testbench

- Read-side controller for the team's 32-bit synchronous FIFO buffer.
- On a start command it pops a programmed number of words from the FIFO and presents them on a valid/ready output stream, marking the final word with a last flag.
- It drives the FIFO's RD strobe, honours EMPTY, and absorbs the FIFO's one-cycle read latency with a 2-entry output skid buffer, so that back-to-back pops are possible under full throughput.

---
 rtl/fifo_burst_reader.sv | 167 ++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Pops a programmed burst from a 1-cycle-latency FIFO onto a valid/ready stream via a 2-entry skid buffer.
// Build option FIFO_RD_TIMEOUT_EN: abort a burst after TIMEOUT consecutive empty stalls, flagged by err with done.
module fifo_burst_reader #(
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_start,
   input  logic [LEN_W-1:0]  i_burst_len,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   input  logic              i_fifo_empty,
   output logic              o_fifo_rd,
   input  logic [DATA_W-1:0] i_fifo_dout,
   output logic              o_m_valid,
   input  logic              i_m_ready,
   output logic [DATA_W-1:0] o_m_data,
   output logic              o_m_last,
   output logic [LEN_W-1:0]  o_rd_count
);
   typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

   state_t            r_state;
   logic [LEN_W-1:0]  r_remaining;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_rd_count;
   logic              r_inflight;
   logic              r_busy;
   logic              r_done;
   logic [1:0]        r_occ;
   logic [DATA_W-1:0] r_buf0;
   logic [DATA_W-1:0] r_buf1;

   logic       w_pop;
   logic       w_rd;
   logic       w_stall;
   logic       w_abort;
   logic       w_drained;
   logic [2:0] w_level;

   // Occupancy the buffer will have once this cycle's pop and in-flight capture settle.
   assign w_pop     = (r_occ != 2'd0) && i_m_ready;
   assign w_level   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_rd      = (r_state == S_READ) && i_en && !i_fifo_empty &&
                      (r_remaining != '0) && (w_level < 3'd2);
   assign w_stall   = (r_state == S_READ) && i_en && i_fifo_empty && (r_remaining != '0);
   assign w_drained = !r_inflight && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop));

`ifdef FIFO_RD_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] r_stall_cnt;
   logic             r_abort;

   assign w_abort = w_stall && (r_stall_cnt == CNT_W'(TIMEOUT - 1));
   assign o_err   = r_done && r_abort;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_stall_cnt <= '0;
         r_abort     <= 1'b0;
      end else begin
         if (w_rd || (r_state != S_READ))
            r_stall_cnt <= '0;
         else if (w_stall)
            r_stall_cnt <= r_stall_cnt + 1'b1;
         else if (i_en)
            r_stall_cnt <= '0;
         if (r_state == S_IDLE)
            r_abort <= 1'b0;
         else if (w_abort)
            r_abort <= 1'b1;
      end
   end
`else
   assign w_abort = 1'b0;
   assign o_err   = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_len       <= '0;
         r_rd_count  <= '0;
         r_inflight  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_inflight <= w_rd;
         r_done     <= 1'b0;
         if (w_pop)
            r_rd_count <= r_rd_count + 1'b1;
         if (w_rd)
            r_remaining <= r_remaining - 1'b1;
         if (i_en) begin
            case (r_state)
               S_IDLE: begin
                  if (i_start && (i_burst_len != '0)) begin
                     r_state     <= S_READ;
                     r_remaining <= i_burst_len;
                     r_len       <= i_burst_len;
                     r_rd_count  <= '0;
                     r_busy      <= 1'b1;
                  end
               end
               S_READ: begin
                  if ((w_rd && (r_remaining == LEN_W'(1))) || w_abort)
                     r_state <= S_FLUSH;
               end
               S_FLUSH: begin
                  if (w_drained) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
               S_DONE:  r_state <= S_IDLE;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Skid buffer: r_buf0 is always the head; pops shift r_buf1 forward.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_occ  <= 2'd0;
         r_buf0 <= '0;
         r_buf1 <= '0;
      end else begin
         case ({r_inflight, w_pop})
            2'b10: begin
               if (r_occ == 2'd0)
                  r_buf0 <= i_fifo_dout;
               else
                  r_buf1 <= i_fifo_dout;
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_buf0 <= r_buf1;
               r_occ  <= r_occ - 2'd1;
            end
            2'b11: begin
               if (r_occ == 2'd1) begin
                  r_buf0 <= i_fifo_dout;
               end else begin
                  r_buf0 <= r_buf1;
                  r_buf1 <= i_fifo_dout;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_fifo_rd  = w_rd;
   assign o_m_valid  = (r_occ != 2'd0);
   assign o_m_data   = r_buf0;
   assign o_m_last   = o_m_valid && (({1'b0, r_rd_count} + (LEN_W+1)'(1)) == {1'b0, r_len});
   assign o_rd_count = r_rd_count;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: FIFO model plus scoreboard-driven output monitor.
module tb_fifo_burst_reader;
   localparam int DW = 32;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          rst_n, en, start, m_ready;
   logic [LW-1:0] blen;
   logic          busy, done, err, fifo_rd, m_valid, m_last, fifo_empty;
   logic [DW-1:0] fifo_dout, m_data;
   logic [LW-1:0] rd_count;

   always #5 clk = ~clk;

   fifo_burst_reader #(.DATA_W(DW), .LEN_W(LW), .TIMEOUT(16)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_start(start), .i_burst_len(blen),
      .o_busy(busy), .o_done(done), .o_err(err), .i_fifo_empty(fifo_empty),
      .o_fifo_rd(fifo_rd), .i_fifo_dout(fifo_dout), .o_m_valid(m_valid),
      .i_m_ready(m_ready), .o_m_data(m_data), .o_m_last(m_last), .o_rd_count(rd_count)
   );

   // FIFO model: one-cycle read latency, 256-deep circular store.
   logic [DW-1:0] mem [0:255];
   int wp = 0;
   int rp = 0;
   assign fifo_empty = (wp == rp);
   always @(posedge clk) begin
      if (fifo_rd) begin
         fifo_dout <= mem[rp[7:0]];
         rp        <= rp + 1;
      end
   end

   int cyc = 0;
   int t0  = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {logic [DW-1:0] d; logic l;} exp_t;
   exp_t sb[$];
   int   rd_log[$], xf_log[$], done_log[$];
   logic err_log[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic          held_vld = 1'b0;
   logic [DW-1:0] held_dat;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (fifo_rd === 1'b1) begin
         rd_log.push_back(cyc - t0);
         chk("rd_while_empty", fifo_empty, 0);
      end
      if (rst_n) begin
         if (held_vld) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, held_dat);
         end
         if (m_valid && m_ready) begin
            xf_log.push_back(cyc - t0);
            if (sb.size() == 0) begin
               chk("unexpected_word", m_data, 64'hDEAD);
            end else begin
               e = sb.pop_front();
               chk("m_data", m_data, e.d);
               chk("m_last", m_last, e.l);
            end
         end
         if (done) begin
            done_log.push_back(cyc - t0);
            err_log.push_back(err);
            chk("busy_at_done", busy, 0);
`ifndef FIFO_RD_TIMEOUT_EN
            chk("err_tied_low", err, 0);
`endif
         end
      end
      held_vld = rst_n && m_valid && !m_ready;
      held_dat = m_data;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic fifo_push(input logic [DW-1:0] d);
      mem[wp[7:0]] = d;
      wp++;
   endtask

   task automatic exp_push(input logic [DW-1:0] d, input logic l);
      exp_t e;
      e.d = d;
      e.l = l;
      sb.push_back(e);
   endtask

   task automatic start_burst(input logic [LW-1:0] len);
      rd_log.delete(); xf_log.delete(); done_log.delete(); err_log.delete();
      start = 1'b1;
      blen  = len;
      t0    = cyc;
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_log.size() == 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (done_log.size() == 0) chk("done_timeout", 0, 1);
      step(1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; en = 1'b1; start = 1'b0; blen = '0; m_ready = 1'b1;
      fifo_dout = '0;
      step(1);
      // Reset with random inputs.
      for (int i = 0; i < 3; i++) begin
         start = 1'($urandom); blen = LW'($urandom); en = 1'($urandom); m_ready = 1'($urandom);
         step(1);
         chk("reset_fifo_rd", fifo_rd, 0);
      end
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_err", err, 0);
      chk("reset_m_valid", m_valid, 0);
      chk("reset_m_last", m_last, 0);
      chk("reset_m_data", m_data, 0);
      chk("reset_rd_count", rd_count, 0);
      start = 1'b0; en = 1'b1; m_ready = 1'b1; blen = '0;
      rst_n = 1'b1;
      step(2);

      // Full throughput, 4 words.
      for (int i = 0; i < 4; i++) begin
         fifo_push(DW'(i));
         exp_push(DW'(i), i == 3);
      end
      start_burst(4);
      chk("ft_busy", busy, 1);
      wait_done(30);
      chk("ft_rd_n", rd_log.size(), 4);
      chk("ft_xf_n", xf_log.size(), 4);
      if (rd_log.size() == 4 && xf_log.size() == 4)
         for (int i = 0; i < 4; i++) begin
            chk("ft_rd_cycle", rd_log[i], i + 1);
            chk("ft_xf_cycle", xf_log[i], i + 3);
         end
      chk("ft_done_cycle", done_log[0], 7);
      chk("ft_rd_count", rd_count, 4);
      chk("ft_busy_after", busy, 0);

      // Backpressure, 5 words.
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         fifo_push(32'hA0 + DW'(i));
         exp_push(32'hA0 + DW'(i), i == 4);
      end
      start_burst(5);
      step(10);
      chk("bp_pops", rd_log.size(), 2);
      chk("bp_valid", m_valid, 1);
      chk("bp_head", m_data, 32'hA0);
      m_ready = 1'b1;
      wait_done(30);
      chk("bp_pops_total", rd_log.size(), 5);
      chk("bp_rd_count", rd_count, 5);

      // Empty stall, then EN=0 hold, then completion.
      fifo_push(32'hB0);
      for (int i = 0; i < 3; i++) exp_push(32'hB0 + DW'(i), i == 2);
      start_burst(3);
      step(8);
      chk("st_pops", rd_log.size(), 1);
      chk("st_busy", busy, 1);
      chk("st_no_done", done_log.size(), 0);
      en = 1'b0;
      fifo_push(32'hB1);
      fifo_push(32'hB2);
      step(4);
      chk("en_low_pops", rd_log.size(), 1);
      en = 1'b1;
      wait_done(30);
      chk("st_pops_total", rd_log.size(), 3);
      chk("st_rd_count", rd_count, 3);

      // Ignored starts: zero length, then start during a burst.
      fifo_push(32'hC0); fifo_push(32'hC1); fifo_push(32'hC2); fifo_push(32'hD0);
      start_burst(0);
      for (int i = 0; i < 3; i++) begin
         chk("zero_len_busy", busy, 0);
         step(1);
      end
      chk("zero_len_pops", rd_log.size(), 0);
      for (int i = 0; i < 3; i++) exp_push(32'hC0 + DW'(i), i == 2);
      start_burst(3);
      step(1);
      start = 1'b1; blen = 4'd4;
      step(1);
      start = 1'b0;
      wait_done(30);
      step(5);
      chk("mid_start_pops", rd_log.size(), 3);
      chk("mid_start_rd_count", rd_count, 3);
      chk("mid_start_busy", busy, 0);

      // Reset in cycle 2 of a 4-word burst (D0 already queued).
      fifo_push(32'hE1); fifo_push(32'hE2); fifo_push(32'hE3);
      start_burst(4);
      step(1);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(1);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_valid", m_valid, 0);
      chk("rst_mid_rd_count", rd_count, 0);
      step(6);
      chk("rst_mid_no_done", done_log.size(), 0);
      chk("rst_mid_pops", rd_log.size(), 2);
      exp_push(32'hE2, 1'b0);
      exp_push(32'hE3, 1'b1);
      start_burst(2);
      wait_done(30);
      chk("drain_rd_count", rd_count, 2);

      // Empty FIFO: timeout abort when compiled in, otherwise an indefinite stall.
      start_burst(2);
`ifdef FIFO_RD_TIMEOUT_EN
      wait_done(60);
      chk("to_err", (err_log.size() > 0) ? err_log[0] : 1'b0, 1);
      chk("to_done_cycle", (done_log.size() > 0) ? done_log[0] : -1, 18);
      chk("to_rd_count", rd_count, 0);
      chk("to_pops", rd_log.size(), 0);
`else
      step(30);
      chk("stall_busy", busy, 1);
      chk("stall_no_done", done_log.size(), 0);
      exp_push(32'hF0, 1'b0);
      exp_push(32'hF1, 1'b1);
      fifo_push(32'hF0);
      fifo_push(32'hF1);
      wait_done(30);
      chk("stall_rd_count", rd_count, 2);
      chk("stall_err", (err_log.size() > 0) ? err_log[0] : 1'b1, 0);
`endif
      chk("sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
